// File: rtl/image_framer_pkg.sv
// Shared geometry and types for the classifier image producer.
// LENGTH rows of WIDTH one-bit pixels; row/col counters are sized from these.
package image_framer_pkg;

  localparam int LENGTH = 4;
  localparam int WIDTH  = 6;

  localparam int ROW_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    FR_IDLE = 2'd0,
    FR_FILL = 2'd1,
    FR_HOLD = 2'd2
  } framer_state_t;

  typedef logic [LENGTH-1:0][WIDTH-1:0] image_t;

endpackage

// File: rtl/image_framer.sv
// Thresholds a raster grey-pixel stream into a LENGTH x WIDTH bit image and
// holds the finished image with frame_valid until the consumer acknowledges it.
module image_framer
  import image_framer_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_sof,
  input  logic [PIX_W-1:0] s_data,
  input  logic [PIX_W-1:0] threshold,
  output image_t           image,
  output logic             frame_valid,
  input  logic             frame_ack,
  output logic             sync_err,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int               PIXELS   = LENGTH * WIDTH;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LENGTH - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic             SINGLE   = (PIXELS == 1) ? 1'b1 : 1'b0;

  framer_state_t    state_r;
  framer_state_t    state_next_s;
  logic             ready_r;
  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] col_r;
  image_t           image_r;
  logic             frame_valid_r;
  logic             sync_err_r;
  logic [CNT_W-1:0] frame_count_r;
  logic [CNT_W-1:0] drop_count_r;

  logic             accept_s;
  logic             pix_bit_s;
  logic             wr_en_s;
  logic [ROW_W-1:0] wr_row_s;
  logic [COL_W-1:0] wr_col_s;
  logic             last_s;
  logic             restart_s;
  logic             drop_s;

  assign accept_s  = s_valid && ready_r;
  assign pix_bit_s = (s_data >= threshold);

  // State register; ready is registered alongside so it is low exactly in HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FR_IDLE;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_next_s;
      ready_r <= (state_next_s != FR_HOLD);
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FR_IDLE: begin
        if (accept_s && s_sof) begin
          state_next_s = last_s ? FR_HOLD : FR_FILL;
        end else begin
          state_next_s = FR_IDLE;
        end
      end
      FR_FILL: begin
        if (last_s) begin
          state_next_s = FR_HOLD;
        end else begin
          state_next_s = FR_FILL;
        end
      end
      FR_HOLD: begin
        if (frame_ack) begin
          state_next_s = FR_IDLE;
        end else begin
          state_next_s = FR_HOLD;
        end
      end
      default: state_next_s = FR_IDLE;
    endcase
  end

  // Per-beat actions: pixel write target, frame completion, resync and drop
  always_comb begin
    wr_en_s   = 1'b0;
    wr_row_s  = '0;
    wr_col_s  = '0;
    last_s    = 1'b0;
    restart_s = 1'b0;
    drop_s    = 1'b0;
    case (state_r)
      FR_IDLE: begin
        if (accept_s && s_sof) begin
          wr_en_s = 1'b1;
          last_s  = SINGLE;
        end else if (accept_s) begin
          drop_s = 1'b1;
        end else begin
          drop_s = 1'b0;
        end
      end
      FR_FILL: begin
        if (accept_s && s_sof) begin
          wr_en_s   = 1'b1;
          restart_s = 1'b1;
          last_s    = SINGLE;
        end else if (accept_s) begin
          wr_en_s  = 1'b1;
          wr_row_s = row_r;
          wr_col_s = col_r;
          last_s   = (row_r == ROW_LAST) && (col_r == COL_LAST);
        end else begin
          wr_en_s = 1'b0;
        end
      end
      FR_HOLD: wr_en_s = 1'b0;
      default: wr_en_s = 1'b0;
    endcase
  end

  // Image, raster position, handshake flags and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r         <= '0;
      col_r         <= '0;
      image_r       <= '0;
      frame_valid_r <= 1'b0;
      sync_err_r    <= 1'b0;
      frame_count_r <= '0;
      drop_count_r  <= '0;
    end else begin
      if (wr_en_s) begin
        image_r[wr_row_s][wr_col_s] <= pix_bit_s;
        if (last_s) begin
          row_r <= '0;
          col_r <= '0;
        end else if (wr_col_s == COL_LAST) begin
          row_r <= wr_row_s + ROW_W'(1);
          col_r <= '0;
        end else begin
          row_r <= wr_row_s;
          col_r <= wr_col_s + COL_W'(1);
        end
      end
      if (last_s) begin
        frame_valid_r <= 1'b1;
        frame_count_r <= frame_count_r + CNT_W'(1);
      end else if ((state_r == FR_HOLD) && frame_ack) begin
        frame_valid_r <= 1'b0;
      end
      sync_err_r <= restart_s;
      if (drop_s && (drop_count_r != {CNT_W{1'b1}})) begin
        drop_count_r <= drop_count_r + CNT_W'(1);
      end
    end
  end

  assign s_ready     = ready_r;
  assign image       = image_r;
  assign frame_valid = frame_valid_r;
  assign sync_err    = sync_err_r;
  assign frame_count = frame_count_r;
  assign drop_count  = drop_count_r;

endmodule

// File: tb/tb_image_framer.sv
// Self-checking bench for image_framer: randomized beats against a pixel-index
// reference model of the framing rules.
module tb_image_framer;
  import image_framer_pkg::*;

  localparam int NPIX = LENGTH * WIDTH;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic        s_sof;
  logic [7:0]  s_data;
  logic [7:0]  threshold;
  image_t      image;
  logic        frame_valid;
  logic        frame_ack;
  logic        sync_err;
  logic [15:0] frame_count;
  logic [15:0] drop_count;

  int tests = 0;
  int fails = 0;

  // reference model state
  bit m_img[LENGTH][WIDTH];
  bit m_hold;
  bit m_fill;
  bit m_sync;
  int m_idx;
  int m_fc;
  int m_dc;

  always #5 clk = ~clk;

  image_framer #(.PIX_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_data(s_data), .threshold(threshold), .image(image), .frame_valid(frame_valid),
    .frame_ack(frame_ack), .sync_err(sync_err), .frame_count(frame_count),
    .drop_count(drop_count)
  );

  function automatic image_t exp_image();
    image_t t;
    for (int r = 0; r < LENGTH; r++)
      for (int c = 0; c < WIDTH; c++)
        t[r][c] = m_img[r][c];
    return t;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < LENGTH; r++)
      for (int c = 0; c < WIDTH; c++)
        m_img[r][c] = 1'b0;
    m_hold = 0; m_fill = 0; m_sync = 0; m_idx = 0; m_fc = 0; m_dc = 0;
  endtask

  // One clock: inputs sampled before the edge, model advanced, return at edge+1
  task automatic step();
    bit acc, bitv, sof_v, ack_v;
    acc   = s_valid && !m_hold;
    bitv  = (s_data >= threshold);
    sof_v = s_sof;
    ack_v = frame_ack;
    @(posedge clk);
    m_sync = 0;
    if (m_hold) begin
      if (ack_v) m_hold = 0;
    end else if (acc) begin
      if (sof_v) begin
        m_sync = m_fill;
        m_idx  = 0;
      end
      if (sof_v || m_fill) begin
        m_img[m_idx / WIDTH][m_idx % WIDTH] = bitv;
        m_idx++;
        m_fill = 1;
        if (m_idx == NPIX) begin
          m_fill = 0;
          m_hold = 1;
          m_idx  = 0;
          m_fc   = (m_fc + 1) % 65536;
        end
      end else if (m_dc < 65535) begin
        m_dc++;
      end
    end
    #1;
  endtask

  function automatic logic [7:0] pix_val(input int kind, input int r, input int c);
    if (kind == 0) return 8'd200;
    if (kind == 1) return (((r + c) % 2) == 0) ? 8'd0 : 8'd255;
    return 8'($urandom);
  endfunction

  task automatic drive_beat(input bit sof, input logic [7:0] d, input int gap_pct);
    for (int g = 0; g < 8 && ($urandom_range(0, 99) < gap_pct); g++) begin
      s_valid = 1'b0;
      s_sof   = 1'($urandom);
      s_data  = 8'($urandom);
      step();
    end
    s_valid = 1'b1;
    s_sof   = sof;
    s_data  = d;
    step();
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send_pixels(input int kind, input int start, input int count,
                             input int gap_pct, input bit first_sof);
    for (int i = 0; i < count; i++) begin
      int idx;
      idx = start + i;
      drive_beat(first_sof && (i == 0), pix_val(kind, idx / WIDTH, idx % WIDTH), gap_pct);
    end
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_fv: got %0b expected 0", frame_valid); end
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b expected 1", s_ready); end
    tests++; if (image !== '0) begin fails++; $display("FAIL reset_image: got %h expected 0", image); end
    tests++; if (frame_count !== 16'd0) begin fails++; $display("FAIL reset_fc: got %0d expected 0", frame_count); end
    tests++; if (drop_count !== 16'd0) begin fails++; $display("FAIL reset_dc: got %0d expected 0", drop_count); end
    tests++; if (sync_err !== 1'b0) begin fails++; $display("FAIL reset_sync: got %0b expected 0", sync_err); end
  endtask

  task automatic test_full_frame();
    threshold = 8'd128;
    send_pixels(0, 0, NPIX - 1, 0, 1'b1);
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL full_early_fv: got %0b expected 0", frame_valid); end
    drive_beat(1'b0, 8'd200, 0);
    tests++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL full_fv: got %0b expected 1", frame_valid); end
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %0b expected 0", s_ready); end
    tests++; if (image !== {(LENGTH*WIDTH){1'b1}}) begin fails++; $display("FAIL full_image: got %h expected all ones", image); end
    tests++; if (frame_count !== 16'd1) begin fails++; $display("FAIL full_fc: got %0d expected 1", frame_count); end
    do_ack();
    tests++; if (frame_valid !== 1'b0 || s_ready !== 1'b1) begin fails++; $display("FAIL full_ack: got fv=%0b ready=%0b expected fv=0 ready=1", frame_valid, s_ready); end
  endtask

  task automatic test_checkerboard();
    int bad;
    threshold = 8'd128;
    send_pixels(1, 0, NPIX, 0, 1'b1);
    bad = 0;
    for (int r = 0; r < LENGTH; r++)
      for (int c = 0; c < WIDTH; c++)
        if (image[r][c] !== 1'((r + c) & 1)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL checker_image: got %h with %0d wrong bits expected 0 wrong", image, bad); end
    tests++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL checker_fv: got %0b expected 1", frame_valid); end
    do_ack();
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL checker_ack_fv: got %0b expected 0", frame_valid); end
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL checker_ack_ready: got %0b expected 1", s_ready); end
    tests++; if (image !== exp_image()) begin fails++; $display("FAIL checker_retain: got %h expected %h", image, exp_image()); end
  endtask

  task automatic test_drop();
    int seen_sync;
    seen_sync = 0;
    for (int i = 0; i < 5; i++) begin
      drive_beat(1'b0, 8'($urandom), 0);
      if (sync_err !== 1'b0 || frame_valid !== 1'b0) seen_sync++;
    end
    tests++; if (seen_sync != 0) begin fails++; $display("FAIL drop_sync: got %0d bad cycles expected 0", seen_sync); end
    tests++; if (drop_count !== 16'd5) begin fails++; $display("FAIL drop_count: got %0d expected 5", drop_count); end
    threshold = 8'($urandom);
    send_pixels(2, 0, NPIX, 0, 1'b1);
    tests++; if (image !== exp_image()) begin fails++; $display("FAIL drop_image: got %h expected %h", image, exp_image()); end
    tests++; if (frame_count !== 16'(m_fc) || drop_count !== 16'(m_dc)) begin fails++; $display("FAIL drop_counts: got fc=%0d dc=%0d expected fc=%0d dc=%0d", frame_count, drop_count, m_fc, m_dc); end
    do_ack();
  endtask

  task automatic test_sync();
    threshold = 8'($urandom);
    send_pixels(2, 0, 2 * WIDTH + 3, 0, 1'b1);
    drive_beat(1'b1, 8'($urandom), 0);
    tests++; if (sync_err !== 1'b1) begin fails++; $display("FAIL sync_pulse: got %0b expected 1", sync_err); end
    drive_beat(1'b0, 8'($urandom), 0);
    tests++; if (sync_err !== 1'b0) begin fails++; $display("FAIL sync_once: got %0b expected 0", sync_err); end
    send_pixels(2, 2, NPIX - 3, 0, 1'b0);
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL sync_early_fv: got %0b expected 0", frame_valid); end
    drive_beat(1'b0, 8'($urandom), 0);
    tests++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL sync_fv: got %0b expected 1", frame_valid); end
    tests++; if (image !== exp_image()) begin fails++; $display("FAIL sync_image: got %h expected %h", image, exp_image()); end
    do_ack();
  endtask

  task automatic test_gaps();
    image_t snap;
    int bad;
    threshold = 8'($urandom);
    send_pixels(2, 0, NPIX, 40, 1'b1);
    tests++; if (frame_valid !== 1'b1 || image !== exp_image()) begin fails++; $display("FAIL gaps_frame: got fv=%0b img=%h expected fv=1 img=%h", frame_valid, image, exp_image()); end
    snap = exp_image();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'($urandom);
      s_sof   = 1'($urandom);
      s_data  = 8'($urandom);
      step();
      if (image !== snap || s_ready !== 1'b0 || frame_valid !== 1'b1) bad++;
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    tests++; if (bad != 0) begin fails++; $display("FAIL gaps_hold: got %0d disturbed cycles expected 0", bad); end
    do_ack();
    tests++; if (frame_valid !== 1'b0 || frame_count !== 16'(m_fc)) begin fails++; $display("FAIL gaps_ack: got fv=%0b fc=%0d expected fv=0 fc=%0d", frame_valid, frame_count, m_fc); end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      frame_ack = 1'b1;
      step();
      if (frame_valid !== 1'b0) bad++;
    end
    frame_ack = 1'b0;
    tests++; if (bad != 0) begin fails++; $display("FAIL gaps_no_rerise: got %0d cycles with fv=1 expected 0", bad); end
  endtask

  task automatic test_async_reset();
    threshold = 8'($urandom);
    send_pixels(2, 0, 10, 0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (frame_valid !== 1'b0 || sync_err !== 1'b0) begin fails++; $display("FAIL rst_fill_flags: got fv=%0b sync=%0b expected 0 0", frame_valid, sync_err); end
    tests++; if (image !== '0 || frame_count !== 16'd0 || drop_count !== 16'd0) begin fails++; $display("FAIL rst_fill_state: got img=%h fc=%0d dc=%0d expected 0 0 0", image, frame_count, drop_count); end
    model_reset();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %0b expected 1", s_ready); end
    send_pixels(2, 0, NPIX, 0, 1'b1);
    tests++; if (frame_valid !== 1'b1 || image !== exp_image() || frame_count !== 16'd1) begin fails++; $display("FAIL rst_frame1: got fv=%0b img=%h fc=%0d expected 1 %h 1", frame_valid, image, frame_count, exp_image()); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (frame_valid !== 1'b0 || image !== '0 || frame_count !== 16'd0) begin fails++; $display("FAIL rst_hold: got fv=%0b img=%h fc=%0d expected 0 0 0", frame_valid, image, frame_count); end
    model_reset();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    threshold = 8'($urandom);
    send_pixels(2, 0, NPIX, 30, 1'b1);
    tests++; if (frame_valid !== 1'b1 || image !== exp_image()) begin fails++; $display("FAIL rst_frame2: got fv=%0b img=%h expected 1 %h", frame_valid, image, exp_image()); end
    do_ack();
  endtask

  initial begin
    s_valid   = 1'b0;
    s_sof     = 1'b0;
    s_data    = 8'd0;
    threshold = 8'd128;
    frame_ack = 1'b0;
    model_reset();
    test_reset();
    test_full_frame();
    test_checkerboard();
    test_drop();
    test_sync();
    test_gaps();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
